// File: rtl/ht_data_ram_ctrl.sv
// ht_data_ram_ctrl
//   Front-end for the hash-table data RAM. It arbitrates ENG_CNT engine read
//   and write ports onto a simple dual-port RAM (port A read, port B write).
//   Read data is routed back with a one-hot per-engine valid. A read that hits
//   the address being written in the same cycle is served from the write data.
//   An external update port and a clear sequencer share the write port.
//   Write priority is clear > update > engine.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   eng_rd_req_i / eng_rd_addr_i      per-engine read requests and addresses
//   eng_rd_gnt_o                      one-hot read grant (combinational)
//   eng_rd_data_o / eng_rd_val_o      shared read data and per-engine valid
//   eng_wr_req_i / _addr_i / _data_i  per-engine write requests
//   eng_wr_gnt_o                      one-hot write grant (combinational)
//   upd_en_i / upd_addr_i / upd_data_i  external update write
//   upd_drop_o                        pulse: an update was discarded during a clear
//   clear_run_i                       start or restart the zero-fill
//   clear_busy_o / clear_done_o       clear in progress / completion pulse
//   ram_rd_* / ram_wr_*               RAM port A (read) and port B (write)

module ht_data_ram_ctrl #(
    parameter int ENG_CNT     = 4,
    parameter int A_WIDTH     = 10,
    parameter int D_WIDTH     = 64,
    parameter int RAM_LATENCY = 1,
    parameter int ARB_MODE    = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ENG_CNT-1:0]           eng_rd_req_i,
    input  logic [ENG_CNT*A_WIDTH-1:0]   eng_rd_addr_i,
    output logic [ENG_CNT-1:0]           eng_rd_gnt_o,
    output logic [D_WIDTH-1:0]           eng_rd_data_o,
    output logic [ENG_CNT-1:0]           eng_rd_val_o,
    input  logic [ENG_CNT-1:0]           eng_wr_req_i,
    input  logic [ENG_CNT*A_WIDTH-1:0]   eng_wr_addr_i,
    input  logic [ENG_CNT*D_WIDTH-1:0]   eng_wr_data_i,
    output logic [ENG_CNT-1:0]           eng_wr_gnt_o,
    input  logic                         upd_en_i,
    input  logic [A_WIDTH-1:0]           upd_addr_i,
    input  logic [D_WIDTH-1:0]           upd_data_i,
    output logic                         upd_drop_o,
    input  logic                         clear_run_i,
    output logic                         clear_busy_o,
    output logic                         clear_done_o,
    output logic [A_WIDTH-1:0]           ram_rd_addr_o,
    output logic                         ram_rd_en_o,
    input  logic [D_WIDTH-1:0]           ram_rd_data_i,
    output logic [A_WIDTH-1:0]           ram_wr_addr_o,
    output logic [D_WIDTH-1:0]           ram_wr_data_o,
    output logic                         ram_wr_en_o
);
    localparam int IDX_W = (ENG_CNT > 1) ? $clog2(ENG_CNT) : 1;
    localparam logic [A_WIDTH:0]   LAST_ADDR = {1'b0, {A_WIDTH{1'b1}}};
    localparam logic [IDX_W-1:0]   PTR_RST   = IDX_W'(ENG_CNT - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CLR = 2'd1, ST_DONE = 2'd2} clr_state_t;

    // Returns {found, index}. Fixed mode: highest requesting index.
    // Round-robin: first requester at or after last+1 (mod ENG_CNT).
    function automatic logic [IDX_W:0] arb_pick(input logic [ENG_CNT-1:0] req,
                                                input logic [IDX_W-1:0]   last);
        logic             found;
        logic [IDX_W-1:0] sel;
        int               idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < ENG_CNT; i++) begin
                if (req[i]) begin
                    found = 1'b1;
                    sel   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= ENG_CNT; k++) begin
                idx = (int'(last) + k) % ENG_CNT;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    sel   = IDX_W'(idx);
                end
            end
        end
        return {found, sel};
    endfunction

    // Unpacked views of the engine buses
    logic [A_WIDTH-1:0] rd_addr [ENG_CNT];
    logic [A_WIDTH-1:0] wr_addr [ENG_CNT];
    logic [D_WIDTH-1:0] wr_data [ENG_CNT];

    genvar gi;
    generate
        for (gi = 0; gi < ENG_CNT; gi++) begin : g_unpack
            assign rd_addr[gi] = eng_rd_addr_i[gi*A_WIDTH +: A_WIDTH];
            assign wr_addr[gi] = eng_wr_addr_i[gi*A_WIDTH +: A_WIDTH];
            assign wr_data[gi] = eng_wr_data_i[gi*D_WIDTH +: D_WIDTH];
        end
    endgenerate

    // State
    clr_state_t         state_q, state_d;
    logic [A_WIDTH:0]   clr_addr_q, clr_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ENG_CNT-1:0] val_pipe_q [RAM_LATENCY];
    logic [ENG_CNT-1:0] val_pipe_d [RAM_LATENCY];
    logic               fwd_pipe_q [RAM_LATENCY];
    logic               fwd_pipe_d [RAM_LATENCY];
    logic [D_WIDTH-1:0] fdat_pipe_q [RAM_LATENCY];
    logic [D_WIDTH-1:0] fdat_pipe_d [RAM_LATENCY];

    // Arbitration
    logic [IDX_W:0]     rd_pick, wr_pick;
    logic               rd_hit, wr_hit;
    logic [IDX_W-1:0]   rd_sel, wr_sel;
    logic [ENG_CNT-1:0] rd_gnt, wr_gnt;

    always_comb begin
        rd_pick = arb_pick(eng_rd_req_i, rd_ptr_q);
        wr_pick = arb_pick(eng_wr_req_i, wr_ptr_q);
        rd_sel  = rd_pick[IDX_W-1:0];
        wr_sel  = wr_pick[IDX_W-1:0];
        // The clear owns both RAM ports' arbitration; an update steals the write port
        rd_hit  = rd_pick[IDX_W] & ~busy_q;
        wr_hit  = wr_pick[IDX_W] & ~busy_q & ~upd_en_i;
        rd_gnt  = '0;
        wr_gnt  = '0;
        if (rd_hit) rd_gnt[rd_sel] = 1'b1;
        if (wr_hit) wr_gnt[wr_sel] = 1'b1;
        rd_ptr_d = rd_hit ? rd_sel : rd_ptr_q;
        wr_ptr_d = wr_hit ? wr_sel : wr_ptr_q;
    end

    // Write port mux
    logic               wr_en;
    logic [A_WIDTH-1:0] wr_a;
    logic [D_WIDTH-1:0] wr_d;
    logic [A_WIDTH-1:0] rd_a;
    logic               fwd_now;

    always_comb begin
        wr_en = 1'b0;
        wr_a  = '0;
        wr_d  = '0;
        if (busy_q) begin
            wr_en = 1'b1;
            wr_a  = clr_addr_q[A_WIDTH-1:0];
        end else if (upd_en_i) begin
            wr_en = 1'b1;
            wr_a  = upd_addr_i;
            wr_d  = upd_data_i;
        end else if (wr_hit) begin
            wr_en = 1'b1;
            wr_a  = wr_addr[wr_sel];
            wr_d  = wr_data[wr_sel];
        end
        rd_a    = rd_hit ? rd_addr[rd_sel] : '0;
        // The RAM reads old data on a same-address collision, so capture the new word
        fwd_now = rd_hit & wr_en & (wr_a == rd_a);
    end

    // Read-return pipeline, aligned with the RAM read latency
    always_comb begin
        val_pipe_d[0]  = rd_gnt;
        fwd_pipe_d[0]  = fwd_now;
        fdat_pipe_d[0] = wr_d;
    end

    generate
        for (gi = 1; gi < RAM_LATENCY; gi++) begin : g_pipe
            assign val_pipe_d[gi]  = val_pipe_q[gi-1];
            assign fwd_pipe_d[gi]  = fwd_pipe_q[gi-1];
            assign fdat_pipe_d[gi] = fdat_pipe_q[gi-1];
        end
    endgenerate

    // Clear sequencer next state
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_run_i) begin
                    state_d    = ST_CLR;
                    clr_addr_d = '0;
                end
            end
            ST_CLR: begin
                if (clear_run_i) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = clear_run_i ? ST_CLR : ST_IDLE;
                clr_addr_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
        endcase
        busy_d = (state_d == ST_CLR);
        done_d = (state_d == ST_DONE);
        drop_d = busy_q & upd_en_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            rd_ptr_q   <= PTR_RST;
            wr_ptr_q   <= PTR_RST;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                val_pipe_q[i]  <= '0;
                fwd_pipe_q[i]  <= 1'b0;
                fdat_pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                val_pipe_q[i]  <= val_pipe_d[i];
                fwd_pipe_q[i]  <= fwd_pipe_d[i];
                fdat_pipe_q[i] <= fdat_pipe_d[i];
            end
        end
    end

    assign eng_rd_gnt_o  = rd_gnt;
    assign eng_wr_gnt_o  = wr_gnt;
    assign eng_rd_val_o  = val_pipe_q[RAM_LATENCY-1];
    assign eng_rd_data_o = fwd_pipe_q[RAM_LATENCY-1] ? fdat_pipe_q[RAM_LATENCY-1] : ram_rd_data_i;
    assign upd_drop_o    = drop_q;
    assign clear_busy_o  = busy_q;
    assign clear_done_o  = done_q;
    assign ram_rd_en_o   = rd_hit;
    assign ram_rd_addr_o = rd_a;
    assign ram_wr_en_o   = wr_en;
    assign ram_wr_addr_o = wr_a;
    assign ram_wr_data_o = wr_d;

endmodule

// File: tb/tb_ht_data_ram_ctrl.sv
// tb_ht_data_ram_ctrl
//   Two controllers (fixed priority and round-robin) share one stimulus stream,
//   each with its own behavioural RAM. A reference model predicts grants, RAM
//   traffic, read returns and clear status every cycle.
//   Reads are expected to return the word the address holds once that cycle's
//   write has been applied.

module tb_ht_data_ram_ctrl;
    localparam int N     = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;
    localparam int HMAX  = 2048;

    logic clk;
    logic rst;
    logic [N-1:0]    rd_req, wr_req;
    logic [N*AW-1:0] rd_addr_v, wr_addr_v;
    logic [N*DW-1:0] wr_data_v;
    logic            upd_en, clear_run;
    logic [AW-1:0]   upd_addr;
    logic [DW-1:0]   upd_data;

    logic [N-1:0]  rd_gnt [2];
    logic [N-1:0]  rd_val [2];
    logic [N-1:0]  wr_gnt [2];
    logic [DW-1:0] rd_data [2];
    logic          upd_drop [2];
    logic          busy [2];
    logic          done [2];
    logic [AW-1:0] ram_rd_addr [2];
    logic          ram_rd_en [2];
    logic [DW-1:0] ram_rd_data [2];
    logic [AW-1:0] ram_wr_addr [2];
    logic [DW-1:0] ram_wr_data [2];
    logic          ram_wr_en [2];

    logic [DW-1:0] ram_mem  [2][DEPTH];
    logic [DW-1:0] ram_pipe [2][LAT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            ht_data_ram_ctrl #(
                .ENG_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW),
                .RAM_LATENCY(LAT), .ARB_MODE(gi)
            ) dut (
                .clk_i(clk), .rst_i(rst),
                .eng_rd_req_i(rd_req), .eng_rd_addr_i(rd_addr_v),
                .eng_rd_gnt_o(rd_gnt[gi]), .eng_rd_data_o(rd_data[gi]),
                .eng_rd_val_o(rd_val[gi]),
                .eng_wr_req_i(wr_req), .eng_wr_addr_i(wr_addr_v),
                .eng_wr_data_i(wr_data_v), .eng_wr_gnt_o(wr_gnt[gi]),
                .upd_en_i(upd_en), .upd_addr_i(upd_addr), .upd_data_i(upd_data),
                .upd_drop_o(upd_drop[gi]),
                .clear_run_i(clear_run), .clear_busy_o(busy[gi]),
                .clear_done_o(done[gi]),
                .ram_rd_addr_o(ram_rd_addr[gi]), .ram_rd_en_o(ram_rd_en[gi]),
                .ram_rd_data_i(ram_rd_data[gi]),
                .ram_wr_addr_o(ram_wr_addr[gi]), .ram_wr_data_o(ram_wr_data[gi]),
                .ram_wr_en_o(ram_wr_en[gi])
            );
            assign ram_rd_data[gi] = ram_pipe[gi][LAT-1];
        end
    endgenerate

    // Behavioural simple dual-port RAM: read-before-write, LAT-cycle read latency
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            ram_pipe[m][0] <= ram_rd_en[m] ? ram_mem[m][ram_rd_addr[m]] : '0;
            for (int s = 1; s < LAT; s++) ram_pipe[m][s] <= ram_pipe[m][s-1];
            if (ram_wr_en[m]) ram_mem[m][ram_wr_addr[m]] <= ram_wr_data[m];
        end
    end

    // Reference model state
    int            n_chk, n_fail, cyc;
    int            m_rd_ptr [2];
    int            m_wr_ptr [2];
    bit            m_busy, m_done, m_drop;
    int            m_caddr;
    logic [DW-1:0] m_mem [2][DEPTH];
    logic [N-1:0]  h_gnt [2][HMAX];
    logic [DW-1:0] h_dat [2][HMAX];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Mode 0: highest requesting index. Mode 1: next requester after the last grant.
    function automatic int pick(input int mode, input logic [N-1:0] req, input int last);
        if (mode == 0) begin
            for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic run_cycle();
        logic [N-1:0]  e_rgnt, e_wgnt, e_val;
        logic          e_wen;
        logic [AW-1:0] e_waddr, e_raddr;
        logic [DW-1:0] e_wdata;
        int            r, w;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            e_val = (cyc >= LAT) ? h_gnt[m][cyc-LAT] : '0;
            check_val($sformatf("rd_val m%0d c%0d", m, cyc), 64'(rd_val[m]), 64'(e_val));
            if (e_val != '0)
                check_val($sformatf("rd_data m%0d c%0d", m, cyc), 64'(rd_data[m]), 64'(h_dat[m][cyc-LAT]));
            check_val($sformatf("busy m%0d c%0d", m, cyc), 64'(busy[m]), 64'(m_busy));
            check_val($sformatf("done m%0d c%0d", m, cyc), 64'(done[m]), 64'(m_done));
            check_val($sformatf("drop m%0d c%0d", m, cyc), 64'(upd_drop[m]), 64'(m_drop));

            r = m_busy ? -1 : pick(m, rd_req, m_rd_ptr[m]);
            w = (m_busy || upd_en) ? -1 : pick(m, wr_req, m_wr_ptr[m]);
            e_rgnt = '0;
            e_wgnt = '0;
            if (r >= 0) e_rgnt[r] = 1'b1;
            if (w >= 0) e_wgnt[w] = 1'b1;
            e_raddr = (r >= 0) ? rd_addr_v[r*AW +: AW] : '0;
            e_wen   = 1'b1;
            e_waddr = '0;
            e_wdata = '0;
            if (m_busy) begin
                e_waddr = AW'(m_caddr);
            end else if (upd_en) begin
                e_waddr = upd_addr;
                e_wdata = upd_data;
            end else if (w >= 0) begin
                e_waddr = wr_addr_v[w*AW +: AW];
                e_wdata = wr_data_v[w*DW +: DW];
            end else begin
                e_wen = 1'b0;
            end

            check_val($sformatf("rd_gnt m%0d c%0d", m, cyc), 64'(rd_gnt[m]), 64'(e_rgnt));
            check_val($sformatf("wr_gnt m%0d c%0d", m, cyc), 64'(wr_gnt[m]), 64'(e_wgnt));
            check_val($sformatf("ram_rd_en m%0d c%0d", m, cyc), 64'(ram_rd_en[m]), 64'(r >= 0));
            check_val($sformatf("ram_rd_addr m%0d c%0d", m, cyc), 64'(ram_rd_addr[m]), 64'(e_raddr));
            check_val($sformatf("ram_wr_en m%0d c%0d", m, cyc), 64'(ram_wr_en[m]), 64'(e_wen));
            if (e_wen) begin
                check_val($sformatf("ram_wr_addr m%0d c%0d", m, cyc), 64'(ram_wr_addr[m]), 64'(e_waddr));
                check_val($sformatf("ram_wr_data m%0d c%0d", m, cyc), 64'(ram_wr_data[m]), 64'(e_wdata));
                m_mem[m][e_waddr] = e_wdata;
            end

            h_gnt[m][cyc] = rst ? '0 : e_rgnt;
            h_dat[m][cyc] = m_mem[m][e_raddr];
            // Reset flushes reads still in flight
            if (rst) for (int k = 1; k < LAT; k++) if (cyc - k >= 0) h_gnt[m][cyc-k] = '0;
            if (r >= 0) m_rd_ptr[m] = r;
            if (w >= 0) m_wr_ptr[m] = w;
            if (rst) begin
                m_rd_ptr[m] = N - 1;
                m_wr_ptr[m] = N - 1;
            end
        end

        m_drop = m_busy && upd_en;
        if (clear_run) begin
            m_busy  = 1'b1;
            m_caddr = 0;
            m_done  = 1'b0;
        end else if (m_busy) begin
            if (m_caddr == DEPTH - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_caddr++;
            end
        end else begin
            m_done = 1'b0;
        end
        if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_drop  = 1'b0;
            m_caddr = 0;
        end
        if (cyc < HMAX - 1) cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rd_req = '0; wr_req = '0; rd_addr_v = '0; wr_addr_v = '0; wr_data_v = '0;
        upd_en = 1'b0; upd_addr = '0; upd_data = '0; clear_run = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        m_busy = 1'b0; m_done = 1'b0; m_drop = 1'b0; m_caddr = 0;
        for (int m = 0; m < 2; m++) begin
            m_rd_ptr[m] = N - 1;
            m_wr_ptr[m] = N - 1;
            for (int a = 0; a < DEPTH; a++) m_mem[m][a] = '0;
            for (int c = 0; c < HMAX; c++) begin
                h_gnt[m][c] = '0;
                h_dat[m][c] = '0;
            end
        end
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) run_cycle();
        rst = 1'b0;
        run_cycle();

        // Full zero-fill, with an update arriving mid-clear
        clear_run = 1'b1; run_cycle(); clear_run = 1'b0;
        for (int i = 0; i < 19; i++) begin
            upd_en = (i == 5); upd_addr = 4'd3; upd_data = 16'h1234;
            run_cycle();
        end
        upd_en = 1'b0;

        // Fixed priority picks engine 3 from 1011
        rd_req = 4'b1011; rd_addr_v = 16'h7C41;
        repeat (3) run_cycle();
        rd_req = '0; repeat (LAT) run_cycle();

        // All engines requesting
        rd_req = 4'b1111; rd_addr_v = 16'h3210;
        repeat (8) run_cycle();
        rd_req = '0; repeat (LAT) run_cycle();

        // Engine 2 writes 0xAA at 5 while engine 1 reads 5, then read again
        rd_req = 4'b0010; rd_addr_v = 16'h0050;
        wr_req = 4'b0100; wr_addr_v = 16'h0500; wr_data_v = 64'h0000_00AA_0000_0000;
        run_cycle();
        wr_req = '0; run_cycle();
        rd_req = '0; repeat (LAT) run_cycle();

        // Update collides with engine 0 write
        upd_en = 1'b1; upd_addr = 4'd9; upd_data = 16'hBEEF;
        wr_req = 4'b0001; wr_addr_v = 16'h0009; wr_data_v = 64'h0000_0000_0000_5A5A;
        run_cycle();
        upd_en = 1'b0; run_cycle();
        wr_req = '0; rd_req = 4'b0001; rd_addr_v = 16'h0009; run_cycle();
        rd_req = '0; repeat (LAT) run_cycle();

        // Clear restarted around address 7
        clear_run = 1'b1; run_cycle(); clear_run = 1'b0;
        repeat (7) run_cycle();
        clear_run = 1'b1; run_cycle(); clear_run = 1'b0;
        repeat (18) run_cycle();

        // Reset aborts a running clear
        clear_run = 1'b1; run_cycle(); clear_run = 1'b0;
        repeat (5) run_cycle();
        rst = 1'b1; run_cycle(); rst = 1'b0;
        repeat (4) run_cycle();

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            rd_req    = N'($urandom);
            wr_req    = N'($urandom);
            rd_addr_v = (N*AW)'($urandom);
            wr_addr_v = (N*AW)'($urandom);
            wr_data_v = {$urandom, $urandom};
            upd_en    = ($urandom_range(0, 9) == 0);
            upd_addr  = AW'($urandom);
            upd_data  = DW'($urandom);
            clear_run = ($urandom_range(0, 149) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            run_cycle();
        end
        set_idle();
        rst = 1'b0;
        repeat (LAT + 2) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
